prefetch_buffer: RTL and testbench

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/prefetch_buffer_pkg.sv | 12 +
 rtl/prefetch_mem.sv | 25 ++
 rtl/prefetch_buffer.sv | 80 ++++++++
 tb/tb_prefetch_buffer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prefetch_buffer_pkg.sv
// Shared widths, entry layout and defaults for the instruction prefetch queue.
package prefetch_buffer_pkg;
    localparam int INSTR_W       = 32;
    localparam int ADDR_W        = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;
endpackage

// File: rtl/prefetch_mem.sv
// Queue storage: DEPTH x 64 register array, one synchronous write port, one combinational read port.
module prefetch_mem
    import prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  entry_t        wr_data,
    input  logic [PW-1:0] rd_addr,
    output entry_t        rd_data
);
    // Contents are qualified by the pointers/count, so the array itself is never reset.
    entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch queue: fetches sequentially into a DEPTH-entry FIFO, flushes on redirect.
module prefetch_buffer
    import prefetch_buffer_pkg::*;
#(
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        target,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_data,
    input  logic                     take,
    output logic                     valid,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;

    logic   wr;
    logic   pop;
    logic   not_empty;
    entry_t wr_entry;
    entry_t head_entry;

    assign not_empty = (count_reg != '0);
    assign pop       = take && not_empty && !redirect;
    // A pop frees a slot in the same cycle, so a full queue can still accept a write.
    assign wr        = !redirect && ((count_reg < CW'(DEPTH)) || (take && not_empty));
    assign wr_entry  = '{instr: imem_data, pc: fetch_pc_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= RESET_PC;
        end else if (redirect) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= {target[ADDR_W-1:2], 2'b00};
        end else begin
            if (wr) begin
                tail_reg     <= tail_reg + PW'(1);
                fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(wr) - CW'(pop);
        end
    end

    prefetch_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr),
        .wr_addr (tail_reg),
        .wr_data (wr_entry),
        .rd_addr (head_reg),
        .rd_data (head_entry)
    );

    assign imem_addr = fetch_pc_reg;
    assign valid     = not_empty;
    assign instr     = not_empty ? head_entry.instr : '0;
    assign pc        = not_empty ? head_entry.pc    : '0;
    assign count     = count_reg;
endmodule

// File: tb/tb_prefetch_buffer.sv
// Randomized bench for prefetch_buffer against a queue-based reference model.
module tb_prefetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic        take = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] imem_addr, imem_data, instr, pc;
    logic        valid;
    logic [2:0]  count;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [31:0] q[$];
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .redirect  (redirect),
        .target    (target),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .take      (take),
        .valid     (valid),
        .instr     (instr),
        .pc        (pc),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_pc;
        exp_pc = (q.size() != 0) ? q[0] : 32'h0;
        check("valid", {31'b0, valid}, {31'b0, q.size() != 0});
        check("count", {29'b0, count}, 32'(q.size()));
        check("pc", pc, exp_pc);
        check("instr", instr, (q.size() != 0) ? mem_word(q[0]) : 32'h0);
        check("imem_addr", imem_addr, m_fpc);
        $display("t=%0t valid=%0b count=%0d pc=%h instr=%h imem_addr=%h", $time, valid, count, pc, instr, imem_addr);
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc = RESET_PC;
    endtask

    // Queue semantics: redirect flushes; otherwise pop the head when taken and
    // append the fetch word whenever a slot is (or is being made) free.
    task automatic model_edge(input logic rd, input logic [31:0] tgt, input logic tk);
        bit popped, wrote;
        if (rd) begin
            q.delete();
            m_fpc = {tgt[31:2], 2'b00};
        end else begin
            popped = tk && (q.size() != 0);
            wrote  = (q.size() < DEPTH) || popped;
            if (popped) void'(q.pop_front());
            if (wrote) begin
                q.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    // Called just after a falling edge: drive, check, clock, update model.
    task automatic cycle(input logic rd, input logic [31:0] tgt, input logic tk);
        redirect = rd;
        target   = tgt;
        take     = tk;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(rd, tgt, tk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Fill with take=0: count climbs to DEPTH, fetch stops at RESET_PC+16.
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
        #1;
        check("fill_count", {29'b0, count}, 32'd4);
        check("fill_addr", imem_addr, RESET_PC + 32'd16);
        check("fill_head", pc, RESET_PC);

        // Streaming from a full queue.
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

        // Redirect at count=3 with take asserted; target low bits dropped.
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0103, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        #1;
        check("redir_pc", pc, 32'h0000_0100);

        // Address wrap at the top of the space.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        #1;
        check("wrap_pc", pc, 32'h0000_0000);

        // Take while empty, then reset mid-stream with a full queue.
        pulse_reset();
        cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        pulse_reset();
        cycle(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: only the later target streams in.
        cycle(1'b1, 32'h0000_0040, 1'b1);
        cycle(1'b1, 32'h0000_0080, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        #1;
        check("b2b_pc", pc, 32'h0000_0080);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic        rd, tk;
            logic [31:0] tgt;
            rd  = ($urandom_range(0, 99) < 6);
            tk  = ($urandom_range(0, 99) < 65);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, tgt[3:0]};
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else cycle(rd, tgt, tk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
